rc_in_fifo_12: RTL and testbench

- Input flit buffer for one input port of router 12. It sits between the incoming link and the routing-computation stage.
- Accepts flits from the link using a valid/ready handshake and stores them first-in-first-out.
- Presents the head flit to the RC stage as data plus valid, and pops it when the RC stage asserts rc_ready.
- Exports its current occupancy as a pressure value. Neighbouring RC units use this value for adaptive direction selection.

---
 rtl/rc_in_fifo_12_if.sv | 51 +++++
 rtl/rc_in_fifo_12.sv | 91 +++++++++
 tb/tb_rc_in_fifo_12.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/rc_in_fifo_12_if.sv
// ----------------------------------------------------------------------------
// rc_in_fifo_12_if
// Handshake bundle between router 12's input flit buffer and its neighbours:
// the upstream link (data_in/valid_in/ready_out) and the routing-computation
// stage (data_out/valid_out/rc_ready), plus the exported occupancy pressure.
//
// Modports:
//   slave  - the flit buffer itself
//   master - the environment around it (upstream link + RC stage)
//
// Signals:
//   data_in      [DATASIZE]  flit from the upstream link
//   valid_in     [1]         upstream flit is valid
//   ready_out    [1]         buffer can accept a flit this cycle
//   data_out     [DATASIZE]  head flit presented to the RC stage
//   valid_out    [1]         head flit is valid
//   rc_ready     [1]         RC stage consumes the head flit this cycle
//   pressure_out [WIDTH+1]   occupancy count, 0..DEPTH
// ----------------------------------------------------------------------------
interface rc_in_fifo_12_if #(
    parameter int DATASIZE = 40,
    parameter int WIDTH    = 3
);
    logic [DATASIZE-1:0] data_in;
    logic                valid_in;
    logic                ready_out;
    logic [DATASIZE-1:0] data_out;
    logic                valid_out;
    logic                rc_ready;
    logic [WIDTH:0]      pressure_out;

    modport slave (
        input  data_in,
        input  valid_in,
        input  rc_ready,
        output ready_out,
        output data_out,
        output valid_out,
        output pressure_out
    );

    modport master (
        output data_in,
        output valid_in,
        output rc_ready,
        input  ready_out,
        input  data_out,
        input  valid_out,
        input  pressure_out
    );
endinterface

// File: rtl/rc_in_fifo_12.sv
// ----------------------------------------------------------------------------
// rc_in_fifo_12
// Input flit buffer for one input port of router 12. Flits arrive from the
// link on a valid/ready handshake, are stored first-in-first-out, and the
// head flit is presented first-word-fall-through to the routing-computation
// stage, which pops it with rc_ready. The occupancy count is exported as a
// pressure value for adaptive direction selection in neighbouring RC units.
//
// Ports:
//   rc_clk  - clock, rising edge active
//   rst_n   - asynchronous, active-low reset
//   link    - rc_in_fifo_12_if.slave: data_in/valid_in/ready_out from the
//             link, data_out/valid_out/rc_ready to the RC stage,
//             pressure_out occupancy count
//
// Flit fields: src[39:36] dst[35:32] timestamp[31:24] data[23:2] type[1:0].
// ----------------------------------------------------------------------------
module rc_in_fifo_12 #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 3,
    parameter int DATASIZE = 40
) (
    input  logic                 rc_clk,
    input  logic                 rst_n,
    rc_in_fifo_12_if.slave       link
);

    localparam logic [WIDTH:0] FULL_COUNT = (WIDTH+1)'(DEPTH);

    logic [DATASIZE-1:0] mem [DEPTH];
    logic [WIDTH-1:0]    wr_ptr;
    logic [WIDTH-1:0]    rd_ptr;
    logic [WIDTH:0]      count;
    logic                push;
    logic                pop;
    logic                not_full;
    logic                not_empty;

    // Full and empty come from the occupancy count rather than pointer
    // equality. ready_out looks only at the registered count, so a pop in the
    // same cycle cannot open the door for a push into a full buffer.
    assign not_full  = (count != FULL_COUNT);
    assign not_empty = (count != '0);
    assign push      = link.valid_in & not_full;
    assign pop       = not_empty & link.rc_ready;

    assign link.ready_out    = not_full;
    assign link.valid_out    = not_empty;
    assign link.pressure_out = count;

    // First-word-fall-through head; forced to zero while empty so the RC
    // stage never sees stale storage contents.
    assign link.data_out = not_empty ? mem[rd_ptr] : '0;

    // Storage has no reset: contents are only meaningful between rd_ptr and
    // wr_ptr, which the count tracks.
    always_ff @(posedge rc_clk) begin
        if (push) begin
            mem[wr_ptr] <= link.data_in;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH == 2**WIDTH.
    always_ff @(posedge rc_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + WIDTH'(1);
            end
        end
    end

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge rc_clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + (WIDTH+1)'(1);
                2'b01:   count <= count - (WIDTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_rc_in_fifo_12.sv
// ----------------------------------------------------------------------------
// tb_rc_in_fifo_12
// Self-checking bench for rc_in_fifo_12: a table of directed vectors for the
// fill/overflow/drain/empty-pop corners, hand-written sequences for
// concurrent push/pop, streaming across pointer wrap and mid-operation reset,
// and a randomized phase checked against a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_rc_in_fifo_12;

    localparam int DEPTH    = 8;
    localparam int WIDTH    = 3;
    localparam int DATASIZE = 40;

    logic rc_clk = 1'b0;
    logic rst_n  = 1'b0;

    rc_in_fifo_12_if #(.DATASIZE(DATASIZE), .WIDTH(WIDTH)) bus ();

    rc_in_fifo_12 #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DATASIZE(DATASIZE)) dut (
        .rc_clk (rc_clk),
        .rst_n  (rst_n),
        .link   (bus.slave)
    );

    always #5 rc_clk = ~rc_clk;

    typedef struct {
        logic                vin;
        logic [DATASIZE-1:0] din;
        logic                rc;
        logic                exp_ready;
        logic                exp_valid;
        logic [DATASIZE-1:0] exp_data;
        logic [WIDTH:0]      exp_press;
    } vec_t;

    vec_t vecs[$];

    // Reference model: the buffer is simply an ordered list of flits.
    logic [DATASIZE-1:0] model_q[$];
    logic [DATASIZE-1:0] exp_popped[$];
    logic [DATASIZE-1:0] dut_popped[$];

    int vectors     = 0;
    int miscompares = 0;

    function automatic vec_t mk(input logic vin, input logic [DATASIZE-1:0] din,
                                input logic rc, input logic er, input logic ev,
                                input logic [DATASIZE-1:0] ed, input logic [WIDTH:0] ep);
        vec_t v;
        v.vin = vin; v.din = din; v.rc = rc;
        v.exp_ready = er; v.exp_valid = ev; v.exp_data = ed; v.exp_press = ep;
        return v;
    endfunction

    task automatic checkField(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, advance the model by its own rules, and
    // record what the RC stage samples on a popping edge.
    task automatic applyStimulus(input logic vin, input logic [DATASIZE-1:0] din,
                                 input logic rc);
        bit m_push;
        bit m_pop;
        bus.valid_in = vin;
        bus.data_in  = din;
        bus.rc_ready = rc;
        m_push = vin && (model_q.size() != DEPTH);
        m_pop  = rc && (model_q.size() != 0);
        if (m_pop) begin
            exp_popped.push_back(model_q[0]);
            dut_popped.push_back(bus.data_out);
        end
        @(posedge rc_clk);
        #1;
        if (m_pop)  void'(model_q.pop_front());
        if (m_push) model_q.push_back(din);
    endtask

    task automatic checkOutput(input string tag);
        int n;
        n = model_q.size();
        checkField({tag, "_ready"},    64'(bus.ready_out),    64'(n != DEPTH));
        checkField({tag, "_valid"},    64'(bus.valid_out),    64'(n != 0));
        checkField({tag, "_data"},     64'(bus.data_out),     (n != 0) ? 64'(model_q[0]) : 64'd0);
        checkField({tag, "_pressure"}, 64'(bus.pressure_out), 64'(n));
    endtask

    task automatic checkStream(input string tag, input logic [DATASIZE-1:0] expected[$]);
        checkField({tag, "_count"}, 64'(dut_popped.size()), 64'(expected.size()));
        for (int i = 0; i < expected.size() && i < dut_popped.size(); i++) begin
            checkField($sformatf("%s_flit%0d", tag, i), 64'(dut_popped[i]), 64'(expected[i]));
        end
    endtask

    task automatic doReset();
        bus.valid_in = 1'b0;
        bus.rc_ready = 1'b0;
        bus.data_in  = '0;
        #2 rst_n = 1'b0;
        #1;
        model_q.delete();
        checkOutput("reset");
        #2 rst_n = 1'b1;
        exp_popped.delete();
        dut_popped.delete();
    endtask

    initial begin : main
        logic [DATASIZE-1:0] sent[$];
        logic [DATASIZE-1:0] stream[$];
        int idx;
        int cyc;

        // Directed table: fill, overflow hold, drain, empty pop, push on
        // empty with rc_ready high, refill, full with simultaneous pop.
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 40'h0A00000001 + 40'(i), 0, (i != 7), 1, 40'h0A00000001, (WIDTH+1)'(i + 1)));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 40'h0A00000009, 0, 0, 1, 40'h0A00000001, 4'd8));
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(0, '0, 1, 1, (k != 7), (k != 7) ? 40'h0A00000002 + 40'(k) : 40'h0,
                              (WIDTH+1)'(7 - k)));
        vecs.push_back(mk(0, '0, 1, 1, 0, 40'h0, 4'd0));
        vecs.push_back(mk(1, 40'h1234567890, 1, 1, 1, 40'h1234567890, 4'd1));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(1, 40'h0B00000001 + 40'(i), 0, (i != 6), 1, 40'h1234567890, (WIDTH+1)'(i + 2)));
        vecs.push_back(mk(1, 40'h0C00000001, 1, 1, 1, 40'h0B00000001, 4'd7));

        bus.valid_in = 1'b0;
        bus.rc_ready = 1'b0;
        bus.data_in  = '0;
        #2;
        checkOutput("por");
        #6 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].vin, vecs[i].din, vecs[i].rc);
            checkField($sformatf("vec%0d_ready", i),    64'(bus.ready_out),    64'(vecs[i].exp_ready));
            checkField($sformatf("vec%0d_valid", i),    64'(bus.valid_out),    64'(vecs[i].exp_valid));
            checkField($sformatf("vec%0d_data", i),     64'(bus.data_out),     64'(vecs[i].exp_data));
            checkField($sformatf("vec%0d_pressure", i), 64'(bus.pressure_out), 64'(vecs[i].exp_press));
        end
        sent.delete();
        for (int i = 0; i < 8; i++) sent.push_back(40'h0A00000001 + 40'(i));
        sent.push_back(40'h1234567890);
        checkStream("drain", sent);

        // Count of 3, then five cycles of simultaneous push and pop.
        doReset();
        sent.delete();
        for (int i = 0; i < 8; i++) sent.push_back(40'h3300000001 + 40'(i));
        for (int i = 0; i < 3; i++) applyStimulus(1, sent[i], 0);
        for (int i = 3; i < 8; i++) begin
            applyStimulus(1, sent[i], 1);
            checkField($sformatf("concur%0d_pressure", i), 64'(bus.pressure_out), 64'd3);
        end
        stream.delete();
        for (int i = 0; i < 5; i++) stream.push_back(sent[i]);
        checkStream("concur", stream);

        // Stream 20 flits with rc_ready toggling, across pointer wrap.
        doReset();
        sent.delete();
        for (int i = 0; i < 20; i++) sent.push_back(40'h4400000000 + 40'(i * 3 + 1));
        idx = 0;
        cyc = 0;
        while ((idx < 20 || model_q.size() != 0) && cyc < 200) begin
            bit accept;
            accept = (idx < 20) && (model_q.size() != DEPTH);
            applyStimulus(idx < 20, (idx < 20) ? sent[idx] : 40'h0, (cyc % 2) == 0);
            if (accept) idx++;
            checkOutput("stream");
            cyc++;
        end
        checkField("stream_done", 64'(cyc < 200), 64'd1);
        checkStream("stream", sent);

        // Asynchronous reset between edges with five flits buffered.
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1, 40'h5500000000 + 40'(i), 0);
        checkField("pre_rst_pressure", 64'(bus.pressure_out), 64'd5);
        bus.valid_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkField("async_rst_valid",    64'(bus.valid_out),    64'd0);
        checkField("async_rst_pressure", 64'(bus.pressure_out), 64'd0);
        checkField("async_rst_ready",    64'(bus.ready_out),    64'd1);
        checkField("async_rst_data",     64'(bus.data_out),     64'd0);
        model_q.delete();
        #2 rst_n = 1'b1;
        applyStimulus(1, 40'hDEADBEEF01, 0);
        checkField("post_rst_head",  64'(bus.data_out),  64'hDEADBEEF01);
        checkField("post_rst_valid", 64'(bus.valid_out), 64'd1);

        // Randomized traffic against the reference model.
        doReset();
        for (int i = 0; i < 400; i++) begin
            logic [DATASIZE-1:0] r;
            r = DATASIZE'({$urandom(), $urandom()});
            applyStimulus($urandom_range(0, 3) != 0, r, $urandom_range(0, 2) != 0);
            checkOutput("rand");
        end
        checkStream("rand_order", exp_popped);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
